// File: rtl/atm_pkg.sv
// Shared constants and state encoding for the ATM session sequencer.
package atm_pkg;

  localparam logic [3:0] ST_ACC_FOUND      = 4'd1;
  localparam logic [3:0] ST_ACC_NOT_FOUND  = 4'd2;
  localparam logic [3:0] ST_PIN_CORRECT    = 4'd3;
  localparam logic [3:0] ST_PIN_INCORRECT  = 4'd4;
  localparam logic [3:0] ST_AMT_VALID      = 4'd5;
  localparam logic [3:0] ST_AMT_INVALID    = 4'd6;
  localparam logic [3:0] ST_EXIT           = 4'd7;
  localparam logic [3:0] ST_INPUT_COMPLETE = 4'd8;

  localparam logic [3:0] IS_SINGLE_KEY      = 4'd1;
  localparam logic [3:0] IS_ACC_NUMBER      = 4'd2;
  localparam logic [3:0] IS_PIN_NUMBER      = 4'd3;
  localparam logic [3:0] IS_MENU_SELECTION  = 4'd4;
  localparam logic [3:0] IS_CURRENCY_TYPE   = 4'd5;
  localparam logic [3:0] IS_CURRENCY_AMOUNT = 4'd6;

  localparam logic [1:0] SEL_BALANCE  = 2'd0;
  localparam logic [1:0] SEL_CONVERT  = 2'd1;
  localparam logic [1:0] SEL_WITHDRAW = 2'd2;
  localparam logic [1:0] SEL_TRANSFER = 2'd3;

  localparam logic [1:0] CUR_USD = 2'd0;
  localparam logic [1:0] CUR_BTC = 2'd1;
  localparam logic [1:0] CUR_ETH = 2'd2;
  localparam logic [1:0] CUR_LTC = 2'd3;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_ACCT = 4'd1,
    LOOKUP   = 4'd2,
    GET_PIN  = 4'd3,
    VERIFY   = 4'd4,
    MENU     = 4'd5,
    GET_CUR  = 4'd6,
    GET_AMT  = 4'd7,
    EXEC     = 4'd8,
    LOCKED   = 4'd9
  } state_t;

  // Waiting states keep the style of the entry that led to them.
  function automatic logic [3:0] style_of(input state_t s);
    case (s)
      GET_ACCT, LOOKUP: style_of = IS_ACC_NUMBER;
      GET_PIN, VERIFY:  style_of = IS_PIN_NUMBER;
      MENU:             style_of = IS_MENU_SELECTION;
      GET_CUR:          style_of = IS_CURRENCY_TYPE;
      GET_AMT:          style_of = IS_CURRENCY_AMOUNT;
      default:          style_of = IS_SINGLE_KEY;
    endcase
  endfunction

endpackage

// File: rtl/atm_session_fsm_timer.sv
// Shared inactivity/lockout counter; expired is high for the single cycle the count sits at tc.
module session_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] tc,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= (count == tc) ? '0 : count + 32'd1;
  end

  assign expired = en && (count == tc);

endmodule

// File: rtl/atm_session_fsm.sv
// Session sequencer: drives the keypad collector, issues datapath requests,
// and enforces PIN lockout and inactivity timeout.
//
// state    | meaning
// IDLE     | no card, waiting for card_start
// GET_ACCT | collecting account number
// LOOKUP   | waiting for account lookup result
// GET_PIN  | collecting PIN
// VERIFY   | waiting for PIN check result
// MENU     | collecting menu selection
// GET_CUR  | collecting currency type
// GET_AMT  | collecting amount
// EXEC     | waiting for transaction result
// LOCKED   | too many wrong PINs, all input ignored
module atm_session_fsm
  import atm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd300000000,
  parameter int unsigned LOCK_CYCLES    = 32'd3000000000,
  parameter int unsigned MAX_PIN_TRIES  = 32'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       card_start,
  input  logic       status_valid,
  input  logic [3:0] status_code,
  input  logic       key_activity,
  input  logic [1:0] menu_sel,
  output logic [3:0] input_style,
  output logic [3:0] cstate,
  output logic       lookup_req,
  output logic       verify_req,
  output logic       txn_req,
  output logic [1:0] txn_type,
  output logic       session_active,
  output logic       lockout,
  output logic       timeout
);

  localparam logic [31:0] TO_TC   = 32'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [31:0] LOCK_TC = 32'(LOCK_CYCLES - 32'd1);

  state_t     state, state_nxt;
  logic [1:0] tries, tries_nxt, tries_inc, txn_type_nxt;
  logic       lookup_nxt, verify_nxt, txn_nxt, timeout_nxt;
  logic       in_session, is_exit, expired, tmr_clr, tmr_en;
  logic [31:0] tmr_tc;

  assign in_session = (state != IDLE) && (state != LOCKED);
  assign is_exit    = status_valid && (status_code == ST_EXIT);
  assign tries_inc  = (tries == 2'd3) ? 2'd3 : tries + 2'd1;

  // Inputs only restart the timer inside a session; LOCKED must run its full count.
  assign tmr_en  = (state != IDLE);
  assign tmr_clr = (state_nxt != state) || (in_session && (key_activity || status_valid));
  assign tmr_tc  = (state == LOCKED) ? LOCK_TC : TO_TC;

  session_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .tc      (tmr_tc),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tries          <= 2'd0;
      txn_type       <= SEL_BALANCE;
      lookup_req     <= 1'b0;
      verify_req     <= 1'b0;
      txn_req        <= 1'b0;
      timeout        <= 1'b0;
      input_style    <= IS_SINGLE_KEY;
      session_active <= 1'b0;
      lockout        <= 1'b0;
    end else begin
      state          <= state_nxt;
      tries          <= tries_nxt;
      txn_type       <= txn_type_nxt;
      lookup_req     <= lookup_nxt;
      verify_req     <= verify_nxt;
      txn_req        <= txn_nxt;
      timeout        <= timeout_nxt;
      input_style    <= style_of(state_nxt);
      session_active <= (state_nxt != IDLE) && (state_nxt != LOCKED);
      lockout        <= (state_nxt == LOCKED);
    end
  end

  assign cstate = state;

  always_comb begin
    state_nxt    = state;
    tries_nxt    = tries;
    txn_type_nxt = txn_type;
    lookup_nxt   = 1'b0;
    verify_nxt   = 1'b0;
    txn_nxt      = 1'b0;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (card_start) begin
          state_nxt = GET_ACCT;
          tries_nxt = 2'd0;
        end
      end
      LOCKED: begin
        if (expired) state_nxt = IDLE;
      end
      default: begin
        if (is_exit) begin
          state_nxt = IDLE;
        end else if (status_valid) begin
          case (state)
            GET_ACCT: if (status_code == ST_INPUT_COMPLETE) begin
              state_nxt  = LOOKUP;
              lookup_nxt = 1'b1;
            end
            LOOKUP: begin
              if (status_code == ST_ACC_FOUND)          state_nxt = GET_PIN;
              else if (status_code == ST_ACC_NOT_FOUND) state_nxt = GET_ACCT;
            end
            GET_PIN: if (status_code == ST_INPUT_COMPLETE) begin
              state_nxt  = VERIFY;
              verify_nxt = 1'b1;
            end
            VERIFY: begin
              if (status_code == ST_PIN_CORRECT) begin
                tries_nxt = 2'd0;
                state_nxt = MENU;
              end else if (status_code == ST_PIN_INCORRECT) begin
                tries_nxt = tries_inc;
                state_nxt = (32'(tries_inc) == MAX_PIN_TRIES) ? LOCKED : GET_PIN;
              end
            end
            MENU: if (status_code == ST_INPUT_COMPLETE) begin
              txn_type_nxt = menu_sel;
              if (menu_sel == SEL_BALANCE) begin
                state_nxt = EXEC;
                txn_nxt   = 1'b1;
              end else begin
                state_nxt = GET_CUR;
              end
            end
            GET_CUR: if (status_code == ST_INPUT_COMPLETE) state_nxt = GET_AMT;
            GET_AMT: if (status_code == ST_INPUT_COMPLETE) begin
              state_nxt = EXEC;
              txn_nxt   = 1'b1;
            end
            EXEC: begin
              if (status_code == ST_AMT_VALID)
                state_nxt = MENU;
              else if (status_code == ST_AMT_INVALID)
                state_nxt = (txn_type == SEL_BALANCE) ? MENU : GET_AMT;
            end
            default: ;
          endcase
        end else if (expired && !key_activity) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_atm_session_fsm.sv
// Table-driven, scoreboarded bench for atm_session_fsm with short timer parameters.
module tb_atm_session_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       card_start = 1'b0, status_valid = 1'b0, key_activity = 1'b0;
  logic [3:0] status_code = 4'd0;
  logic [1:0] menu_sel = 2'd0;
  logic [3:0] input_style, cstate;
  logic       lookup_req, verify_req, txn_req, session_active, lockout, timeout;
  logic [1:0] txn_type;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  atm_session_fsm #(.TIMEOUT_CYCLES(20), .LOCK_CYCLES(10), .MAX_PIN_TRIES(3)) dut (
    .clk(clk), .rst_n(rst_n), .card_start(card_start), .status_valid(status_valid),
    .status_code(status_code), .key_activity(key_activity), .menu_sel(menu_sel),
    .input_style(input_style), .cstate(cstate), .lookup_req(lookup_req),
    .verify_req(verify_req), .txn_req(txn_req), .txn_type(txn_type),
    .session_active(session_active), .lockout(lockout), .timeout(timeout)
  );

  typedef struct {
    logic       card;
    logic       sv;
    logic [3:0] code;
    logic       key;
    logic [1:0] sel;
    logic [3:0] cs;
    logic       lk;
    logic       vf;
    logic       tx;
    logic [1:0] tt;
    logic       to;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic card, input logic sv, input logic [3:0] code,
                              input logic key, input logic [1:0] sel, input logic [3:0] cs,
                              input logic lk, input logic vf, input logic tx,
                              input logic [1:0] tt, input logic to);
    vec_t v;
    v.card = card; v.sv = sv; v.code = code; v.key = key; v.sel = sel;
    v.cs = cs; v.lk = lk; v.vf = vf; v.tx = tx; v.tt = tt; v.to = to;
    return v;
  endfunction

  function automatic vec_t st(input logic [3:0] code, input logic [1:0] sel, input logic [3:0] cs,
                              input logic lk, input logic vf, input logic tx, input logic [1:0] tt);
    return mk(1'b0, 1'b1, code, 1'b0, sel, cs, lk, vf, tx, tt, 1'b0);
  endfunction

  function automatic vec_t idle(input logic [3:0] cs, input logic to);
    return mk(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, cs, 1'b0, 1'b0, 1'b0, 2'd0, to);
  endfunction

  // Expected keypad mode per state; 0 = not checked (EXEC).
  function automatic logic [3:0] exp_style(input logic [3:0] cs);
    case (cs)
      4'd1, 4'd2: return 4'd2;
      4'd3, 4'd4: return 4'd3;
      4'd5:       return 4'd4;
      4'd6:       return 4'd5;
      4'd7:       return 4'd6;
      4'd8:       return 4'd0;
      default:    return 4'd1;
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    card_start = v.card; status_valid = v.sv; status_code = v.code;
    key_activity = v.key; menu_sel = v.sel;
    sb.push_back(v);
    @(posedge clk);
    #1;
    card_start = 1'b0; status_valid = 1'b0; key_activity = 1'b0; status_code = 4'd0;
    if (sb.size() == 0) begin
      chk("sb_empty", idx, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("cstate", idx, cstate, e.cs);
      if (exp_style(e.cs) != 4'd0) chk("input_style", idx, input_style, exp_style(e.cs));
      chk("lookup_req", idx, lookup_req, e.lk);
      chk("verify_req", idx, verify_req, e.vf);
      chk("txn_req", idx, txn_req, e.tx);
      if (e.tx) chk("txn_type", idx, txn_type, e.tt);
      chk("timeout", idx, timeout, e.to);
      chk("lockout", idx, lockout, e.cs == 4'd9);
      chk("session_active", idx, session_active, (e.cs != 4'd0) && (e.cs != 4'd9));
    end
  endtask

  task automatic enter_get_pin(input int base);
    apply(mk(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0), base);
    apply(st(4'd8, 2'd0, 4'd2, 1'b1, 1'b0, 1'b0, 2'd0), base + 1);
    apply(st(4'd1, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0), base + 2);
  endtask

  task automatic chk_reset_values(input int idx);
    chk("rst_cstate", idx, cstate, 4'd0);
    chk("rst_style", idx, input_style, 4'd1);
    chk("rst_lookup", idx, lookup_req, 1'b0);
    chk("rst_verify", idx, verify_req, 1'b0);
    chk("rst_txn", idx, txn_req, 1'b0);
    chk("rst_txn_type", idx, txn_type, 2'd0);
    chk("rst_timeout", idx, timeout, 1'b0);
    chk("rst_lockout", idx, lockout, 1'b0);
    chk("rst_active", idx, session_active, 1'b0);
  endtask

  initial begin
    // happy path, BALANCE and AMT_INVALID handling, EXIT in EXEC
    tbl.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(st(4'd8, 2'd0, 4'd2, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd1, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd4, 1'b0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(st(4'd3, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd2, 4'd6, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd7, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd8, 1'b0, 1'b0, 1'b1, 2'd2));
    tbl.push_back(idle(4'd8, 1'b0));
    tbl.push_back(st(4'd5, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd8, 1'b0, 1'b0, 1'b1, 2'd0));
    tbl.push_back(st(4'd6, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd3, 4'd6, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd7, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd8, 1'b0, 1'b0, 1'b1, 2'd3));
    tbl.push_back(st(4'd6, 2'd0, 4'd7, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd8, 1'b0, 1'b0, 1'b1, 2'd3));
    tbl.push_back(st(4'd7, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    // ACC_NOT_FOUND retry, INPUT_COMPLETE ignored in LOOKUP
    tbl.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(st(4'd8, 2'd0, 4'd2, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd2, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd8, 2'd0, 4'd2, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(st(4'd1, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0));
    // three wrong PINs -> LOCKED, card_start/EXIT/keys ignored, release after 10 cycles
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(st(4'd8, 2'd0, 4'd4, 1'b0, 1'b1, 1'b0, 2'd0));
      tbl.push_back(st(4'd4, 2'd0, (i == 2) ? 4'd9 : 4'd3, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    tbl.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'd9, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(st(4'd7, 2'd0, 4'd9, 1'b0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 2'd0, 4'd9, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    for (int i = 4; i <= 9; i++) tbl.push_back(idle(4'd9, 1'b0));
    tbl.push_back(idle(4'd0, 1'b0));

    #12;
    chk_reset_values(0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // 20 idle cycles in GET_PIN -> single timeout pulse
    enter_get_pin(100);
    for (int k = 1; k <= 19; k++) apply(idle(4'd3, 1'b0), 100 + k);
    apply(idle(4'd0, 1'b1), 120);
    apply(idle(4'd0, 1'b0), 121);

    // key_activity at cycle 15 pushes the timeout to cycle 35
    enter_get_pin(200);
    for (int k = 1; k <= 34; k++)
      apply(mk(1'b0, 1'b0, 4'd0, k == 15, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0), 200 + k);
    apply(idle(4'd0, 1'b1), 235);

    // asynchronous reset while in EXEC with txn_req high
    enter_get_pin(300);
    apply(st(4'd8, 2'd0, 4'd4, 1'b0, 1'b1, 1'b0, 2'd0), 303);
    apply(st(4'd3, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0), 304);
    apply(st(4'd8, 2'd2, 4'd6, 1'b0, 1'b0, 1'b0, 2'd0), 305);
    apply(st(4'd8, 2'd0, 4'd7, 1'b0, 1'b0, 1'b0, 2'd0), 306);
    apply(st(4'd8, 2'd0, 4'd8, 1'b0, 1'b0, 1'b1, 2'd2), 307);
    #1 rst_n = 1'b0;
    #1 chk_reset_values(308);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_txn", 309, txn_req, 1'b0);
    chk("post_rst_cstate", 309, cstate, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
